// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter slice.
// Defaults here are what the arbiter, its picker and its interface fall back to.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_N         = 8;
  localparam int ARB_IDX_W     = $clog2(ARB_N);
  localparam int ARB_HOLD_MAX  = 4;

  // Widest supported requester count; callers truncate to their own N.
  localparam int ARB_N_MAX     = 16;
  localparam int ARB_IDX_W_MAX = 4;

  function automatic logic [ARB_N_MAX-1:0] onehot_f(input logic [ARB_IDX_W_MAX-1:0] idx);
    return {{(ARB_N_MAX-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_if #(
  parameter int N     = arb_pkg::ARB_N,
  parameter int IDX_W = $clog2(N)
) ();

  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);

endinterface

// File: rtl/rr_arbiter_pick.sv
// Circular first-set-bit picker: scans req from ptr upward, wrapping at N-1.
// The doubled vector shifted by ptr turns the circular scan into a plain priority encode.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [N-1:0]     pick_oh,
  output logic [IDX_W-1:0] pick_idx
);

  logic [N-1:0]     rot_s;
  logic [IDX_W-1:0] off_s;

  // Rotate so bit 0 is the ptr position, then find the lowest set bit.
  always_comb begin
    rot_s = N'({req, req} >> ptr);
    off_s = {IDX_W{1'b0}};
    for (int j = N - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        off_s = IDX_W'(j);
      end else begin
        off_s = off_s;
      end
    end
    found    = |rot_s;
    // N is a power of two, so the IDX_W-bit add wraps modulo N.
    pick_idx = ptr + off_s;
    pick_oh  = found ? ({{(N-1){1'b0}}, 1'b1} << pick_idx) : {N{1'b0}};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one owner at a time, held while requesting,
// rotated away after HOLD_MAX cycles when someone else is waiting.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDX_W    = $clog2(N),
  parameter int HOLD_MAX = ARB_HOLD_MAX
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter_if.slave  bus
);

  localparam int              HC_W       = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HC_W-1:0] HOLD_MAX_C = HC_W'(HOLD_MAX);

  arb_state_e       state_r;
  logic [IDX_W-1:0] owner_r;
  logic [IDX_W-1:0] ptr_r;
  logic [HC_W-1:0]  hold_cnt_r;
  logic [N-1:0]     gnt_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic             gnt_valid_r;

  logic [N-1:0]     owner_oh_s;
  logic             owner_req_s;
  logic [IDX_W-1:0] next_ptr_s;
  logic [N-1:0]     cand_s;
  logic [IDX_W-1:0] start_s;
  logic             found_s;
  logic [N-1:0]     pick_oh_s;
  logic [IDX_W-1:0] pick_idx_s;

  // While granting, both release and preempt pick among the others starting at owner+1,
  // so one picker serves IDLE (start at ptr) and GRANT (start at owner+1, owner masked).
  always_comb begin
    owner_oh_s  = N'(onehot_f(ARB_IDX_W_MAX'(owner_r)));
    owner_req_s = |(bus.req & owner_oh_s);
    next_ptr_s  = owner_r + IDX_W'(1);
    cand_s      = (state_r == ARB_GRANT) ? (bus.req & ~owner_oh_s) : bus.req;
    start_s     = (state_r == ARB_GRANT) ? next_ptr_s : ptr_r;
  end

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req      (cand_s),
    .ptr      (start_s),
    .found    (found_s),
    .pick_oh  (pick_oh_s),
    .pick_idx (pick_idx_s)
  );

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ARB_IDLE;
      owner_r     <= {IDX_W{1'b0}};
      ptr_r       <= {IDX_W{1'b0}};
      hold_cnt_r  <= {HC_W{1'b0}};
      gnt_r       <= {N{1'b0}};
      gnt_idx_r   <= {IDX_W{1'b0}};
      gnt_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (found_s) begin
            state_r     <= ARB_GRANT;
            owner_r     <= pick_idx_s;
            hold_cnt_r  <= HC_W'(1);
            gnt_r       <= pick_oh_s;
            gnt_idx_r   <= pick_idx_s;
            gnt_valid_r <= 1'b1;
          end else begin
            hold_cnt_r  <= {HC_W{1'b0}};
            gnt_r       <= {N{1'b0}};
            gnt_idx_r   <= {IDX_W{1'b0}};
            gnt_valid_r <= 1'b0;
          end
        end
        ARB_GRANT: begin
          if (!owner_req_s) begin
            ptr_r <= next_ptr_s;
            if (found_s) begin
              owner_r     <= pick_idx_s;
              hold_cnt_r  <= HC_W'(1);
              gnt_r       <= pick_oh_s;
              gnt_idx_r   <= pick_idx_s;
              gnt_valid_r <= 1'b1;
            end else begin
              state_r     <= ARB_IDLE;
              owner_r     <= {IDX_W{1'b0}};
              hold_cnt_r  <= {HC_W{1'b0}};
              gnt_r       <= {N{1'b0}};
              gnt_idx_r   <= {IDX_W{1'b0}};
              gnt_valid_r <= 1'b0;
            end
          end else if ((HOLD_MAX_C != {HC_W{1'b0}}) && (hold_cnt_r >= HOLD_MAX_C) && found_s) begin
            ptr_r       <= next_ptr_s;
            owner_r     <= pick_idx_s;
            hold_cnt_r  <= HC_W'(1);
            gnt_r       <= pick_oh_s;
            gnt_idx_r   <= pick_idx_s;
            gnt_valid_r <= 1'b1;
          end else begin
            if ((HOLD_MAX_C != {HC_W{1'b0}}) && (hold_cnt_r < HOLD_MAX_C)) begin
              hold_cnt_r <= hold_cnt_r + HC_W'(1);
            end else begin
              hold_cnt_r <= hold_cnt_r;
            end
          end
        end
        default: begin
          state_r     <= ARB_IDLE;
          owner_r     <= {IDX_W{1'b0}};
          hold_cnt_r  <= {HC_W{1'b0}};
          gnt_r       <= {N{1'b0}};
          gnt_idx_r   <= {IDX_W{1'b0}};
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed scoreboard bench: a HOLD_MAX=4 arbiter and a HOLD_MAX=0 arbiter see the same
// request stream; the driver queues hand-computed owners, the monitor compares each cycle.
module tb_rr_arbiter;

  logic clk;
  logic rst;

  rr_arbiter_if #(.N(8), .IDX_W(3)) bus ();
  rr_arbiter_if #(.N(8), .IDX_W(3)) bus0 ();

  rr_arbiter #(.N(8), .IDX_W(3), .HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rr_arbiter #(.N(8), .IDX_W(3), .HOLD_MAX(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // e / e0: expected owner for each arbiter, -1 means no grant.
  typedef struct {
    int e;
    int e0;
    string tag;
  } exp_t;

  exp_t  q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  string phase  = "init";

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int e, input logic v,
                     input logic [2:0] idx, input logic [7:0] g);
    logic       ev;
    logic [2:0] eidx;
    logic [7:0] eg;
    ev   = (e >= 0);
    eidx = ev ? 3'(e) : 3'd0;
    eg   = ev ? (8'h01 << eidx) : 8'h00;
    n_chk++;
    if (v === ev && idx === eidx && g === eg) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t: got valid=%b idx=%0d gnt=%h, want valid=%b idx=%0d gnt=%h",
               name, $time, v, idx, g, ev, eidx, eg);
    end
  endtask

  task automatic inv(input string name, input logic v, input logic [2:0] idx, input logic [7:0] g);
    n_chk++;
    if ($onehot0(g) && (v ? (g === (8'h01 << idx)) : (g === 8'h00 && idx === 3'd0))) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t: got valid=%b idx=%0d gnt=%h, want zero or one-hot gnt matching idx",
               name, $time, v, idx, g);
    end
  endtask

  task automatic cyc(input logic [7:0] r, input logic rv, input int e, input int e0);
    exp_t x;
    @(negedge clk);
    rst      = rv;
    bus.req  = r;
    bus0.req = r;
    x.e   = e;
    x.e0  = e0;
    x.tag = phase;
    q.push_back(x);
  endtask

  // Monitor: compare the queued expectation and the grant invariants after each edge.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk({x.tag, "/hold4"}, x.e,  bus.gnt_valid,  bus.gnt_idx,  bus.gnt);
        chk({x.tag, "/hold0"}, x.e0, bus0.gnt_valid, bus0.gnt_idx, bus0.gnt);
      end
      inv("onehot/hold4", bus.gnt_valid,  bus.gnt_idx,  bus.gnt);
      inv("onehot/hold0", bus0.gnt_valid, bus0.gnt_idx, bus0.gnt);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst      = 1'b1;
    bus.req  = 8'h00;
    bus0.req = 8'h00;

    phase = "reset";
    cyc(8'h00, 1'b1, -1, -1);
    cyc(8'h00, 1'b1, -1, -1);

    // ptr=0: each owner drops its bit for one cycle, handing off without a gap.
    phase = "rotate";
    cyc(8'hFF, 1'b0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(~(8'h01 << ((k - 1) % 8)), 1'b0, k % 8, k % 8);
    end
    cyc(8'h00, 1'b0, -1, -1);

    phase = "single";
    cyc(8'h01, 1'b0, 0, 0);
    cyc(8'h00, 1'b0, -1, -1);
    cyc(8'h00, 1'b0, -1, -1);

    // Owner 7 drops while requester 0 stays: handoff to 0, ptr wraps to 0.
    phase = "simult";
    cyc(8'h80, 1'b0, 7, 7);
    cyc(8'h81, 1'b0, 7, 7);
    cyc(8'h01, 1'b0, 0, 0);

    // Owner 0 already has one cycle; HOLD_MAX=4 alternates 0/3, HOLD_MAX=0 keeps 0.
    phase = "preempt";
    for (int k = 0; k < 3; k++) cyc(8'h09, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(8'h09, 1'b0, 3, 0);
    for (int k = 0; k < 4; k++) cyc(8'h09, 1'b0, 0, 0);
    cyc(8'h09, 1'b0, 3, 0);
    cyc(8'h00, 1'b0, -1, -1);

    phase = "nocontend";
    for (int k = 0; k < 20; k++) cyc(8'h04, 1'b0, 2, 2);
    cyc(8'h00, 1'b0, -1, -1);

    // Requester 4 pulses while 2 owns and is never granted afterwards.
    phase = "nolatch";
    cyc(8'h04, 1'b0, 2, 2);
    cyc(8'h14, 1'b0, 2, 2);
    cyc(8'h04, 1'b0, 2, 2);
    cyc(8'h00, 1'b0, -1, -1);
    cyc(8'h00, 1'b0, -1, -1);

    // ptr is 3 here, so 0x20 picks 5; reset mid-cycle must clear outputs before any edge.
    phase = "rst_mid";
    cyc(8'h20, 1'b0, 5, 5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async/hold4", -1, bus.gnt_valid,  bus.gnt_idx,  bus.gnt);
    chk("rst_async/hold0", -1, bus0.gnt_valid, bus0.gnt_idx, bus0.gnt);
    cyc(8'h20, 1'b1, -1, -1);
    cyc(8'h20, 1'b0, 5, 5);

    // After reset ptr is 0, so 0x21 after a release from 5 would pick 0; here check 0x24 from IDLE.
    phase = "post_rst";
    cyc(8'h00, 1'b1, -1, -1);
    cyc(8'h24, 1'b0, 2, 2);
    cyc(8'h00, 1'b0, -1, -1);

    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
